ro_freq_counter: RTL
====================

# ro_freq_counter

Measures the frequency of a ring-oscillator output by counting its rising edges inside a gate window whose boundaries are the one-cycle `gate_tick` pulses from the sensor's clock divider. At each gate boundary the count is latched into a one-deep output register and offered downstream with a valid/ready handshake. Counting restarts on the same boundary, so windows are back-to-back with no dead cycles. Sits directly after the divider in the RO sensor path and feeds the readout/transmit logic.

## Interface
- `CNT_W`, 24: width of edge counter and `count_data`.
- `clk` input 1: 100 MHz system clock; all logic on its rising edge.
- `rst` input 1: reset; one clock; reset is asynchronous and active-high.
- `en` input 1: measurement enable, synchronous to `clk`.
- `gate_tick` input 1: one-cycle gate pulse from the divider; marks window boundaries.
- `ro_in` input 1: ring-oscillator signal (pre-divided), asynchronous to `clk`; frequency must be < clk/4.
- `count_data` output CNT_W: edge count of the last completed window.
- `count_valid` output 1: `count_data` holds an unconsumed result.
- `count_ready` input 1: downstream accepts; transfer when valid && ready at a rising edge.
- `overrun` output 1: sticky, a completed window was dropped because the output register was full.
- `ovf` output 1: `count_data` of the current result overflowed/saturated (valid with `count_valid`).

## Operation
- `ro_in` passes a 2-FF synchronizer then an edge register; `rise` = sync2 & ~sync3, one cycle wide per `ro_in` rising edge.
- States: IDLE, ARM, MEAS. Reset state IDLE.
- IDLE: counter held 0. `en`=1 -> ARM.
- ARM: waits for first `gate_tick` (partial window discarded). On `gate_tick` -> MEAS, counter loads `rise`.
- MEAS: counter += `rise`. On `gate_tick`: result = counter (excludes `rise` of that cycle), counter loads `rise`; stay MEAS.
- `rise` coincident with `gate_tick` belongs to the new window.
- Result load: if !`count_valid` or (`count_valid` && `count_ready`): `count_data` <= result, `count_valid` <= 1. Else result dropped, `overrun` <= 1.
- Transfer with no new result that cycle: `count_valid` <= 0; `count_data` held.
- `en`=0 in any state: next state IDLE, counter cleared; a pending result stays valid until accepted. `overrun` cleared when `en`=0.
- Counter width CNT_W, unsigned; overflow handling per Configuration; `ovf` accompanies the result it applies to.

## Timing
- Reset values: `count_data`=0, `count_valid`=0, `overrun`=0, `ovf`=0, state IDLE, synchronizer flops 0.
- `ro_in` rise to `rise` pulse: 2-3 clk cycles (sampling uncertainty).
- `gate_tick` at edge k -> `count_valid`/`count_data` updated at edge k+1 (visible cycle after tick).
- Window length equals the `gate_tick` period in clk cycles; expected count = window_cycles / ro_period_cycles.
- `rst` mid-window: everything returns to reset values immediately; first result requires ARM again.

## Configuration
- `RO_CNT_SAT_EN` defined: counter saturates at 2^CNT_W-1; `ovf` set for that result.
- Not defined: counter wraps modulo 2^CNT_W; `ovf` set for that result when any wrap occurred in the window.
- `ovf` port exists in both builds.

## Structure
- `ro_sensor_pkg`: `CNT_W_DEF` constant, state enum (IDLE/ARM/MEAS).
- Sub-module `ro_sync_edge`: 2-FF synchronizer + rising-edge pulse; instanced once for `ro_in`.

## Test plan
- Reset: hold `rst`, toggle `ro_in` -> all outputs 0, state IDLE; release with `en`=0 -> no `count_valid`.
- Basic: `en`=1, `gate_tick` every 100 cycles, `ro_in` period 10 cycles, `count_ready`=1 -> first result after second tick, `count_data`=10 (±1), `count_valid` one cycle each window.
- Backpressure: `count_ready`=0 for 3 windows -> first result held stable, `overrun`=1 after second tick; raise ready -> transfer, `count_valid` drops next cycle.
- Simultaneous: result arriving on cycle of transfer -> `count_valid` stays 1, `count_data` takes new value, no `overrun`.
- Overflow: CNT_W=4, 20 edges per window -> with `RO_CNT_SAT_EN` `count_data`=15, `ovf`=1; without, `count_data`=4, `ovf`=1.
- Mid-run: drop `en` mid-window -> IDLE, pending result still delivered; assert `rst` mid-window -> outputs 0 immediately.

Source files
------------

// File: rtl/ro_sensor_pkg.sv
// Shared types for the ring-oscillator sensor path:
// default counter width, FSM states, counter operations.
package ro_sensor_pkg;

  localparam int CNT_W_DEF = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CNT_CLR  = 2'd0,
    CNT_LOAD = 2'd1,
    CNT_INC  = 2'd2,
    CNT_HOLD = 2'd3
  } cnt_op_t;

endpackage

// File: rtl/ro_sync_edge.sv
// 2-FF synchronizer plus edge register for an async input.
// Ports: clk, rst (async high), din (async), rise (1-cycle pulse).
module ro_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic sync3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise = sync2 & ~sync3;

endmodule

// File: rtl/ro_freq_counter.sv
// Counts ro_in rising edges per gate_tick window; result
// offered via count_valid/count_ready one-deep register.
// Ports: clk, rst, en, gate_tick, ro_in, count_data,
// count_valid, count_ready, overrun (sticky), ovf.
// Macro RO_CNT_SAT_EN: counter saturates instead of wrapping.
module ro_freq_counter
  import ro_sensor_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             gate_tick,
  input  logic             ro_in,
  output logic [CNT_W-1:0] count_data,
  output logic             count_valid,
  input  logic             count_ready,
  output logic             overrun,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  state_t           state_nxt;
  cnt_op_t          cnt_op;
  logic             res_new;
  logic             rise;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] rise_w;
  logic             cnt_ovf;
  logic             at_max;

  ro_sync_edge u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (ro_in),
    .rise (rise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    state_nxt = ARM;
        ARM:     if (gate_tick) state_nxt = MEAS;
        MEAS:    state_nxt = MEAS;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // The partial window seen in ARM is never counted.
  always_comb begin
    cnt_op  = CNT_HOLD;
    res_new = 1'b0;
    if (!en) begin
      cnt_op = CNT_CLR;
    end else begin
      unique case (state)
        IDLE: cnt_op = CNT_CLR;
        ARM:  cnt_op = gate_tick ? CNT_LOAD : CNT_CLR;
        MEAS: begin
          if (gate_tick) begin
            cnt_op  = CNT_LOAD;
            res_new = 1'b1;
          end else begin
            cnt_op  = CNT_INC;
          end
        end
        default: cnt_op = CNT_CLR;
      endcase
    end
  end

  assign rise_w = {{(CNT_W-1){1'b0}}, rise};
  assign at_max = (cnt == CNT_MAX);

`ifdef RO_CNT_SAT_EN
  assign cnt_inc = at_max ? cnt : cnt + rise_w;
`else
  assign cnt_inc = cnt + rise_w;
`endif

  // A rise on the boundary cycle opens the new window,
  // so LOAD takes rise rather than zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      cnt_ovf <= 1'b0;
    end else begin
      unique case (cnt_op)
        CNT_CLR: begin
          cnt     <= '0;
          cnt_ovf <= 1'b0;
        end
        CNT_LOAD: begin
          cnt     <= rise_w;
          cnt_ovf <= 1'b0;
        end
        CNT_INC: begin
          cnt <= cnt_inc;
          if (at_max && rise) cnt_ovf <= 1'b1;
        end
        default: begin
          cnt     <= cnt;
          cnt_ovf <= cnt_ovf;
        end
      endcase
    end
  end

  // Output slot frees in the same cycle it is consumed,
  // so a result landing on a transfer cycle is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_data  <= '0;
      count_valid <= 1'b0;
      overrun     <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      if (res_new) begin
        if (!count_valid || count_ready) begin
          count_data  <= cnt;
          ovf         <= cnt_ovf;
          count_valid <= 1'b1;
        end else begin
          overrun     <= 1'b1;
        end
      end else if (count_valid && count_ready) begin
        count_valid <= 1'b0;
      end
      if (!en) overrun <= 1'b0;
    end
  end

endmodule
